data_mem_ctrl: RTL

// - Sequences the single-port data memory for the SEQ Y86-64 core and shares it between two requesters.
// - Requester D is the Memory stage (icode/valA/valP/valE); requester F is Fetch (instruction word reads).
// - Decodes icode into read/write, address and write-data; checks the address range; arbitrates; returns valM/err.

---
 rtl/data_mem_ctrl_pkg.sv | 32 +++
 rtl/data_mem_ctrl_mem_op_decode.sv | 32 +++
 rtl/data_mem_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the Y86-64 data memory controller: icode values,
// FSM state encoding, memory operation kinds and the address range check.
package data_mem_ctrl_pkg;

    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MEM_OP_NONE = 2'd0,
        MEM_OP_RD   = 2'd1,
        MEM_OP_WR   = 2'd2
    } mem_op_t;

    // An address is bad when it is not 8-byte aligned or when the word it
    // names would run past the end of memory. The compare is on the full
    // 64-bit value, so negative addresses come out as errors.
    function automatic logic addr_err(input logic [63:0] addr,
                                      input logic [63:0] last_word);
        return (addr[2:0] != 3'b000) || (addr > last_word);
    endfunction

endpackage

// File: rtl/data_mem_ctrl_mem_op_decode.sv
// Combinational decode of a Memory-stage instruction into a memory operation,
// its byte address and its write data.
import data_mem_ctrl_pkg::*;

module data_mem_ctrl_mem_op_decode (
    input  logic [3:0]  icode,
    input  logic [63:0] val_a,
    input  logic [63:0] val_p,
    input  logic [63:0] val_e,
    output mem_op_t     op,
    output logic [63:0] addr,
    output logic [63:0] wdata
);

    // Map icode to operation; non-memory instructions decode to NONE with
    // zero address/data so they never trip the range check.
    always_comb begin
        op    = MEM_OP_NONE;
        addr  = '0;
        wdata = '0;
        case (icode)
            ICODE_RMMOVQ: begin op = MEM_OP_WR; addr = val_e; wdata = val_a; end
            ICODE_MRMOVQ: begin op = MEM_OP_RD; addr = val_e; end
            ICODE_CALL:   begin op = MEM_OP_WR; addr = val_e; wdata = val_p; end
            ICODE_RET:    begin op = MEM_OP_RD; addr = val_a; end
            ICODE_PUSHQ:  begin op = MEM_OP_WR; addr = val_e; wdata = val_a; end
            ICODE_POPQ:   begin op = MEM_OP_RD; addr = val_a; end
            default:      ;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory sequencer for the SEQ Y86-64 core. Arbitrates between the
// Memory stage (D) and Fetch (F), range-checks the address, drives one RAM
// access and returns a one-cycle ack with read data and error flag.
import data_mem_ctrl_pkg::*;

module data_mem_ctrl #(
    parameter int ADDR_W     = 13,
    parameter int MEM_BYTES  = 8192,
    parameter int MAX_STREAK = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              d_req,
    input  logic [3:0]        d_icode,
    input  logic [63:0]       d_valA,
    input  logic [63:0]       d_valP,
    input  logic [63:0]       d_valE,
    output logic              d_ack,
    output logic [63:0]       d_valM,
    output logic              d_err,
    input  logic              f_req,
    input  logic [63:0]       f_addr,
    output logic              f_ack,
    output logic [63:0]       f_data,
    output logic              f_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata
);

    localparam int          STREAK_W  = $clog2(MAX_STREAK + 1);
    localparam logic [63:0] LAST_WORD = 64'(MEM_BYTES - 8);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    mem_op_t     d_op;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;

    data_mem_ctrl_mem_op_decode u_decode (
        .icode (d_icode),
        .val_a (d_valA),
        .val_p (d_valP),
        .val_e (d_valE),
        .op    (d_op),
        .addr  (d_addr),
        .wdata (d_wdata)
    );

    state_t              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                win_f_q, win_f_d;
    logic                rd_q, rd_d;
    logic                d_ack_q, d_ack_d;
    logic                f_ack_q, f_ack_d;
    logic                d_err_q, d_err_d;
    logic                f_err_q, f_err_d;
    logic                rd_resp_q, rd_resp_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [63:0]         mem_wdata_q, mem_wdata_d;

    logic                grant_f;
    mem_op_t             sel_op;
    logic [63:0]         sel_addr;
    logic [63:0]         sel_wdata;
    logic                sel_err;

    // Next-state, arbitration, streak and registered-output computation.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        win_f_d     = win_f_q;
        rd_d        = rd_q;
        d_ack_d     = 1'b0;
        f_ack_d     = 1'b0;
        d_err_d     = 1'b0;
        f_err_d     = 1'b0;
        rd_resp_d   = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        grant_f     = 1'b0;
        sel_op      = MEM_OP_NONE;
        sel_addr    = '0;
        sel_wdata   = '0;
        sel_err     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (d_req || f_req) begin
                    // D has priority until F has watched MAX_STREAK D grants.
                    grant_f   = f_req && (!d_req || (streak_q == STREAK_MAX));
                    sel_op    = grant_f ? MEM_OP_RD : d_op;
                    sel_addr  = grant_f ? f_addr    : d_addr;
                    sel_wdata = grant_f ? 64'd0     : d_wdata;
                    sel_err   = (sel_op != MEM_OP_NONE) && addr_err(sel_addr, LAST_WORD);

                    if (grant_f || !f_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 1'b1;
                    end

                    win_f_d = grant_f;
                    rd_d    = (sel_op == MEM_OP_RD);

                    if (sel_err || (sel_op == MEM_OP_NONE)) begin
                        // Nothing to do at the RAM: answer on the next cycle.
                        state_d = ST_RESP;
                        d_ack_d = !grant_f;
                        f_ack_d = grant_f;
                        d_err_d = !grant_f && sel_err;
                        f_err_d = grant_f && sel_err;
                    end else begin
                        state_d     = ST_ACC;
                        mem_en_d    = 1'b1;
                        mem_we_d    = (sel_op == MEM_OP_WR);
                        mem_addr_d  = sel_addr[ADDR_W-1:0];
                        mem_wdata_d = sel_wdata;
                    end
                end
            end
            ST_ACC: begin
                state_d   = ST_RESP;
                d_ack_d   = !win_f_q;
                f_ack_d   = win_f_q;
                rd_resp_d = rd_q;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any access in flight.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            streak_q    <= '0;
            win_f_q     <= 1'b0;
            rd_q        <= 1'b0;
            d_ack_q     <= 1'b0;
            f_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            f_err_q     <= 1'b0;
            rd_resp_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            win_f_q     <= win_f_d;
            rd_q        <= rd_d;
            d_ack_q     <= d_ack_d;
            f_ack_q     <= f_ack_d;
            d_err_q     <= d_err_d;
            f_err_q     <= f_err_d;
            rd_resp_q   <= rd_resp_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign d_ack     = d_ack_q;
    assign f_ack     = f_ack_q;
    assign d_err     = d_err_q;
    assign f_err     = f_err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // The RAM's read register already lands in the ack cycle, so read data is
    // passed straight through, gated by registered ack/read flags.
    assign d_valM = (d_ack_q && rd_resp_q) ? mem_rdata : 64'd0;
    assign f_data = (f_ack_q && rd_resp_q) ? mem_rdata : 64'd0;

endmodule
